// File: rtl/mac_pkg.sv
// Shared types for the MAC operand streamer: FSM states, operand width
// and the operand pair carried through the FIFO.
package mac_pkg;

  localparam int unsigned OPND_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } stream_state_t;

  typedef struct packed {
    logic signed [OPND_W-1:0] a;
    logic signed [OPND_W-1:0] b;
  } mac_pair_t;

endpackage

// File: rtl/mac_pair_fifo.sv
// Synchronous FIFO of operand pairs with registered full/empty flags.
// Push is ignored while full and pop is ignored while empty.
module mac_pair_fifo
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic      clk,
  input  logic      reset_n,
  input  logic      push,
  input  mac_pair_t wr_data,
  input  logic      pop,
  output mac_pair_t rd_data,
  output logic      full,
  output logic      empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  mac_pair_t       mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic [AW:0]     count_nxt;
  logic            do_push;
  logic            do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];

  // Next occupancy, used to register the flags one cycle ahead
  always_comb begin
    count_nxt = count;
    if (do_push && !do_pop) begin
      count_nxt = count + (AW+1)'(1);
    end else if (!do_push && do_pop) begin
      count_nxt = count - (AW+1)'(1);
    end
  end

  // Pointers, occupancy and status flags
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
      full  <= (count_nxt == (AW+1)'(DEPTH));
      empty <= (count_nxt == '0);
    end
  end

  // Storage array; contents need no reset since the pointers gate reads
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/mac_operand_streamer.sv
// Feeds buffered operand pairs to the pipelined MAC, issuing len pairs per
// vector and pulsing done once len results have come back.
module mac_operand_streamer
  import mac_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [CNT_W-1:0]         len,
  output logic                     busy,
  output logic                     done,
  input  logic                     s_valid,
  output logic                     s_ready,
  input  logic signed [OPND_W-1:0] s_a,
  input  logic signed [OPND_W-1:0] s_b,
  output logic signed [OPND_W-1:0] m_a,
  output logic signed [OPND_W-1:0] m_b,
  output logic                     m_valid,
  input  logic                     mac_valid_out
);

  stream_state_t    state;
  logic [CNT_W-1:0] len_q;
  logic [CNT_W-1:0] iss;
  logic [CNT_W-1:0] res;
  logic [CNT_W-1:0] res_nxt;
  logic             fifo_full;
  logic             fifo_empty;
  logic             push;
  logic             pop;
  mac_pair_t        wr_pair;
  mac_pair_t        rd_pair;

  assign s_ready = !fifo_full;
  assign push    = s_valid && !fifo_full;
  assign pop     = (state == ST_RUN) && !fifo_empty && (iss < len_q);
  assign wr_pair = {s_a, s_b};

  // Result count including this cycle's MAC pulse
  always_comb begin
    res_nxt = res;
    if (mac_valid_out) res_nxt = res + CNT_W'(1);
  end

  mac_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wr_data (wr_pair),
    .pop     (pop),
    .rd_data (rd_pair),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // Vector sequencing FSM with registered MAC-side and status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      len_q   <= '0;
      iss     <= '0;
      res     <= '0;
      m_a     <= '0;
      m_b     <= '0;
      m_valid <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      m_valid <= 1'b0;
      done    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            len_q <= len;
            iss   <= '0;
            res   <= '0;
            if (len == '0) begin
              state <= ST_DONE;
              done  <= 1'b1;
            end else begin
              state <= ST_RUN;
              busy  <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          res <= res_nxt;
          if (pop) begin
            m_a     <= rd_pair.a;
            m_b     <= rd_pair.b;
            m_valid <= 1'b1;
            iss     <= iss + CNT_W'(1);
            if (iss + CNT_W'(1) == len_q) state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          res <= res_nxt;
          if (res_nxt == len_q) begin
            state <= ST_DONE;
            done  <= 1'b1;
            busy  <= 1'b0;
          end
        end
        ST_DONE: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mac_operand_streamer.sv
// Bench for mac_operand_streamer: table of vectors plus hand-written corner
// sequences, a pair scoreboard and a 7-cycle MAC valid echo model.
module tb_mac_operand_streamer;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              start = 1'b0;
  logic [7:0]        len = '0;
  logic              busy;
  logic              done;
  logic              s_valid = 1'b0;
  logic              s_ready;
  logic signed [7:0] s_a = '0;
  logic signed [7:0] s_b = '0;
  logic signed [7:0] m_a;
  logic signed [7:0] m_b;
  logic              m_valid;
  logic              mac_valid_out;
  logic              inj = 1'b0;
  logic [6:0]        pipe;

  int checks = 0;
  int failures = 0;
  int mv_cnt = 0;
  int done_cnt = 0;
  int busy_drop = 0;
  int seq_n = 0;
  logic in_vec = 1'b0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;

  typedef struct {
    int len;
    int prefill;
    int exp_lat;
    int exp_mv;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  mac_operand_streamer #(
    .DEPTH (8),
    .CNT_W (8)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start         (start),
    .len           (len),
    .busy          (busy),
    .done          (done),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_a           (s_a),
    .s_b           (s_b),
    .m_a           (m_a),
    .m_b           (m_b),
    .m_valid       (m_valid),
    .mac_valid_out (mac_valid_out)
  );

  // MAC model: valid_out echoes valid_in 7 cycles later
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pipe <= '0;
    else          pipe <= {pipe[5:0], m_valid};
  end
  assign mac_valid_out = pipe[6] | inj;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Output monitor: scoreboard pairs, count m_valid and done pulses
  always @(negedge clk) begin
    if (reset_n && m_valid) begin
      mv_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL m_valid_unexpected: got pair %0d,%0d expected none", m_a, m_b);
      end else begin
        mon_e = exp_q.pop_front();
        chk("m_pair", {16'h0, m_a, m_b}, {16'h0, mon_e});
      end
    end
    if (reset_n && done) done_cnt++;
    if (reset_n && in_vec && !busy && !done) busy_drop++;
  end

  task automatic push_pair();
    logic signed [7:0] a;
    logic signed [7:0] b;
    logic ok;
    a = 8'(2 * seq_n + 1);
    b = 8'(2 * seq_n + 2);
    seq_n++;
    s_a = a;
    s_b = b;
    s_valid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 100; t++) begin
      @(negedge clk);
      if (s_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL push_timeout: got s_ready=0 expected 1");
    end else begin
      @(posedge clk);
      exp_q.push_back({a, b});
    end
    #1 s_valid = 1'b0;
  endtask

  task automatic wait_done(input int k0, output int lat);
    lat = -1;
    for (int k = k0; k <= k0 + 300; k++) begin
      if (done) begin
        lat = k;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic run_vec(input string name, input int l, input int exp_lat, input int exp_mv);
    int lat;
    int mv0;
    int d0;
    mv0 = mv_cnt;
    d0 = done_cnt;
    busy_drop = 0;
    start = 1'b1;
    len = 8'(l);
    @(posedge clk);
    #1 start = 1'b0;
    in_vec = (l != 0);
    chk($sformatf("%s_busy", name), {31'h0, busy}, (l != 0) ? 1 : 0);
    wait_done(0, lat);
    in_vec = 1'b0;
    chk($sformatf("%s_lat", name), lat, exp_lat);
    chk($sformatf("%s_mvalid", name), mv_cnt - mv0, exp_mv);
    chk($sformatf("%s_busyhold", name), busy_drop, 0);
    @(posedge clk);
    #1;
    chk($sformatf("%s_done_pulse", name), {31'h0, done}, 0);
    chk($sformatf("%s_done_cnt", name), done_cnt - d0, 1);
  endtask

  initial begin
    int lat;
    int d0;
    int mv0;
    logic signed [7:0] a9;
    logic signed [7:0] b9;

    tbl = '{'{3, 3, 11, 3}, '{1, 1, 9, 1}, '{5, 7, 13, 5},
            '{0, 0, 0, 0}, '{2, 0, 10, 2}, '{8, 8, 16, 8}};

    // Reset values
    #2;
    chk("rst_m_valid", {31'h0, m_valid}, 0);
    chk("rst_m_ab", {16'h0, m_a, m_b}, 0);
    chk("rst_busy", {31'h0, busy}, 0);
    chk("rst_done", {31'h0, done}, 0);
    chk("rst_s_ready", {31'h0, s_ready}, 1);
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;

    // Table-driven vectors (row 0 is the basic (1,2),(3,4),(5,6) stream;
    // row 2 leaves 2 entries that survive the len=0 row and feed row 4)
    for (int i = 0; i < 6; i++) begin
      for (int p = 0; p < tbl[i].prefill; p++) push_pair();
      run_vec($sformatf("row%0d", i), tbl[i].len, tbl[i].exp_lat, tbl[i].exp_mv);
    end
    chk("rows_q_empty", exp_q.size(), 0);

    // Empty FIFO during RUN: one push every 3 cycles
    d0 = done_cnt;
    start = 1'b1;
    len = 8'd4;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      s_a = 8'(2 * seq_n + 1);
      s_b = 8'(2 * seq_n + 2);
      seq_n++;
      s_valid = 1'b1;
      @(posedge clk);
      exp_q.push_back({s_a, s_b});
      #1 s_valid = 1'b0;
      chk("trickle_mv_e0", {31'h0, m_valid}, 0);
      @(posedge clk);
      #1 chk("trickle_mv_e1", {31'h0, m_valid}, 1);
      @(posedge clk);
      #1 chk("trickle_mv_e2", {31'h0, m_valid}, 0);
    end
    chk("trickle_no_early_done", done_cnt - d0, 0);
    wait_done(12, lat);
    chk("trickle_lat", lat, 19);

    // Full FIFO, held 9th pair, leftover entries
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) push_pair();
    chk("full_s_ready", {31'h0, s_ready}, 0);
    a9 = 8'(2 * seq_n + 1);
    b9 = 8'(2 * seq_n + 2);
    seq_n++;
    s_a = a9;
    s_b = b9;
    s_valid = 1'b1;
    start = 1'b1;
    len = 8'd5;
    @(posedge clk);
    #1 start = 1'b0;
    chk("full_s_ready_S", {31'h0, s_ready}, 0);
    @(posedge clk);
    #1 chk("full_s_ready_S1", {31'h0, s_ready}, 1);
    @(posedge clk);
    exp_q.push_back({a9, b9});
    #1 s_valid = 1'b0;
    wait_done(2, lat);
    chk("full_lat", lat, 13);
    @(posedge clk);
    #1;
    run_vec("leftover", 4, 12, 4);
    chk("leftover_q_empty", exp_q.size(), 0);

    // Ignored events: mac_valid_out in IDLE, start in RUN, DRAIN and DONE
    inj = 1'b1;
    @(posedge clk);
    #1 inj = 1'b0;
    chk("idle_pulse_busy", {31'h0, busy}, 0);
    chk("idle_pulse_done", {31'h0, done}, 0);
    for (int i = 0; i < 3; i++) push_pair();
    mv0 = mv_cnt;
    start = 1'b1;
    len = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1 start = 1'b1;
    len = 8'd1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
    end
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done(6, lat);
    chk("ign_lat", lat, 11);
    chk("ign_mvalid", mv_cnt - mv0, 3);
    start = 1'b1;
    len = 8'd2;
    @(posedge clk);
    #1 start = 1'b0;
    chk("ign_done_start_busy", {31'h0, busy}, 0);
    @(posedge clk);
    #1 chk("ign_done_start_busy2", {31'h0, busy}, 0);
    chk("ign_done_start_done", {31'h0, done}, 0);

    // Mid-vector asynchronous reset
    for (int i = 0; i < 4; i++) push_pair();
    d0 = done_cnt;
    start = 1'b1;
    len = 8'd4;
    @(posedge clk);
    #1 start = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("mid_pre_mvalid", {31'h0, m_valid}, 1);
    chk("mid_pre_busy", {31'h0, busy}, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_rst_mvalid", {31'h0, m_valid}, 0);
    chk("mid_rst_mab", {16'h0, m_a, m_b}, 0);
    chk("mid_rst_busy", {31'h0, busy}, 0);
    chk("mid_rst_done", {31'h0, done}, 0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    mv0 = mv_cnt;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_after_s_ready", {31'h0, s_ready}, 1);
    chk("mid_no_done", done_cnt - d0, 0);
    chk("mid_no_mvalid", mv_cnt - mv0, 0);
    push_pair();
    run_vec("post_reset", 1, 9, 1);
    chk("final_q_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mac_operand_streamer.md
# mac_operand_streamer

Upstream feeder for the pipelined multiply-accumulate unit. Accepts signed 8-bit operand pairs from a producer over a valid/ready handshake and buffers them in a small FIFO. On `start`, issues exactly `len` pairs to the MAC's `a`/`b`/`valid_in` inputs, one per cycle when data is available. It then counts the MAC's `valid_out` pulses and pulses `done` once all `len` results have emerged, so the controller knows when `f` holds the final dot product.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of `len` and of the issue/result counters.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `start` in 1: begin a vector; sampled only in IDLE.
- `len` in CNT_W: number of pairs for this vector; sampled with `start`.
- `busy` out 1: high in RUN and DRAIN.
- `done` out 1: one-cycle pulse when the vector completes.
- `s_valid` in 1: producer has a pair.
- `s_ready` out 1: FIFO not full.
- `s_a`, `s_b` in 8 signed: producer operands.
- `m_a`, `m_b` out 8 signed: to the MAC's `a`/`b`.
- `m_valid` out 1: to the MAC's `valid_in`.
- `mac_valid_out` in 1: from the MAC's `valid_out`.

## Operation
- **FIFO.**
  - Push on `s_valid && s_ready`.
  - `s_ready` is the registered not-full flag and is independent of the pop. When full, `s_ready` stays low even in a cycle that pops.
  - Pushes are accepted in every state, so the producer may prefetch before `start`.
- **States:** IDLE, RUN, DRAIN, DONE.
- **IDLE.**
  - On `start`: latch `len`, clear the issue count `iss` and the result count `res`.
  - If `len` is 0, go to DONE. Otherwise go to RUN.
  - `start` outside IDLE is ignored.
- **RUN.**
  - When the FIFO is non-empty and `iss` < `len`: pop one entry, register it onto `m_a`/`m_b`, assert `m_valid` for the next cycle, and increment `iss`.
  - When the FIFO is empty: `m_valid` is 0 next cycle and `m_a`/`m_b` hold their values (no bubble fill).
  - When the final pop occurs (`iss` reaches `len`), go to DRAIN.
- **Result counting.** `res` increments on `mac_valid_out` in RUN and DRAIN only. Pulses seen in IDLE or DONE are ignored.
- **DRAIN.**
  - `m_valid` is 0 after the last issued pair.
  - When `res` equals `len`, counting the current cycle's pulse, go to DONE.
- **DONE.** `done` is 1 for exactly one cycle, then go to IDLE. `start` during DONE is ignored.
- **Unused FIFO entries.** Entries beyond `len` remain in the FIFO for the next vector and are never dropped.
- **Counters.** `iss` and `res` are CNT_W bits and never wrap, because both stop at `len` ≤ 2^CNT_W−1.
- **Reset while asserted (`reset_n` low).**
  - FIFO pointers and count are cleared; contents are discarded.
  - State goes to IDLE. Counters are 0.
  - Output values while in reset: `m_a`=0, `m_b`=0, `m_valid`=0, `busy`=0, `done`=0, and `s_ready`=1.
- **Mid-vector reset.** Aborts with no `done`. The MAC must be reset alongside.

## Timing
- All outputs are registered. There is no combinational path from inputs to outputs.
- **Push-to-issue latency.** A pair accepted at edge E into an empty FIFO, in RUN, is popped at edge E+1. `m_valid` is high in the cycle after E+1.
- **`start` on a non-empty FIFO.** `start` is sampled at edge S. The first pop is at S+1, so `m_valid` is first high after S+1.
- **Throughput.** One pair per cycle while the FIFO is non-empty. With continuous supply, `len` consecutive `m_valid` cycles.
- **`done` timing.** `done` is asserted the cycle after the edge that samples the `len`-th `mac_valid_out`.
- **`busy`.** Falls in the same cycle that `done` rises.
- **`s_ready` after full.** `s_ready` deasserts the cycle after the FIFO becomes full. It reasserts the cycle after any pop from full.

## Structure
- **Shared package `mac_pkg`:**
  - `stream_state_t` enum (IDLE, RUN, DRAIN, DONE).
  - `OPND_W` = 8.
  - `mac_pair_t` packed struct {signed `a`, signed `b`}.
- **Sub-module `mac_pair_fifo`:** synchronous FIFO of `mac_pair_t`.
  - Parameter `DEPTH`.
  - Async active-low reset, registered full/empty flags, `push`/`pop` ports.
- The streamer adds the FSM, the counters and the output registers around it.

## Test plan
- **Basic stream.** Prefill pairs (1,2),(3,4),(5,6). Then `start`, `len`=3, and the MAC model echoes each `m_valid` after 7 cycles.
  - Required: 3 consecutive `m_valid` cycles with (1,2),(3,4),(5,6).
  - `done` pulses once, one cycle after the 3rd `mac_valid_out`.
  - `busy` is high throughout.
- **Empty FIFO during RUN.** `start`, `len`=4 with an empty FIFO, then push one pair every 3 cycles.
  - Required: `m_valid` high for exactly 4 isolated cycles, each following its push by 2 edges.
  - No `done` until the 4th result.
- **Full FIFO and leftover entries.** Push 8 pairs while IDLE; a 9th is offered with `s_valid` held.
  - Required: `s_ready`=0 after the 8th push.
  - `start` with `len`=5: the 9th pair is accepted the cycle after `s_ready` rises.
  - 4 entries remain after DONE.
- **`len`=0.** `start` with `len`=0.
  - Required: `done` pulses the next cycle; `m_valid` stays 0; the FIFO is untouched.
- **Ignored events.** `start` during RUN and DRAIN, and `mac_valid_out` in IDLE.
  - Required: no effect on `len`; `res` stays 0 in IDLE.
- **Mid-vector reset.** Drive `reset_n` low in the middle of RUN.
  - Required: all outputs 0 immediately (asynchronous), `s_ready`=1 after release, FIFO empty, and no `done`.
